// File: rtl/reg_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : reg_counter_bank
// Description : Bank of CHANNELS independent up/down counters, each with its
//               own programmable wrap limit. One channel is addressed per
//               cycle through `sel`; all values are readable in parallel on
//               `all_out`.
//
// Configuration macro:
//   COUNTER_CASCADE_EN - when defined, an increment that wraps channel k also
//                        increments channel k+1 in the same cycle, rippling
//                        upward through the bank. Decrements never cascade.
//                        When undefined, no cascade logic is built.
//
// Ports:
//   clk       in   1                    rising-edge clock
//   rst       in   1                    synchronous active-high reset
//   sel       in   SEL_W                target channel (>= CHANNELS: no-op)
//   write_en  in   1                    load data_in into value[sel]
//   limit_en  in   1                    load data_in into limit[sel]
//   data_in   in   WORD_SIZE            load data
//   clr       in   1                    clear value[sel]
//   inc       in   1                    step value[sel] up by STEP
//   dec       in   1                    step value[sel] down by STEP
//   data_out  out  WORD_SIZE            value[sel] (0 when sel out of range)
//   all_out   out  CHANNELS*WORD_SIZE   channel k at [k*WORD_SIZE +: WORD_SIZE]
//   wrap      out  CHANNELS             one-cycle registered wrap pulse
//   at_limit  out  CHANNELS             value[k] == limit[k]
//
// Revision    : 1.0 - initial release
// ============================================================================
module reg_counter_bank #(
  parameter int WORD_SIZE = 16,
  parameter int CHANNELS  = 4,
  parameter int STEP      = 1,
  localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          write_en,
  input  logic                          limit_en,
  input  logic [WORD_SIZE-1:0]          data_in,
  input  logic                          clr,
  input  logic                          inc,
  input  logic                          dec,
  output logic [WORD_SIZE-1:0]          data_out,
  output logic [CHANNELS*WORD_SIZE-1:0] all_out,
  output logic [CHANNELS-1:0]           wrap,
  output logic [CHANNELS-1:0]           at_limit
);

  // STEP in both the native width and one bit wider, so the increment sum
  // can be compared against the limit without losing the carry.
  localparam logic [WORD_SIZE-1:0] c_step     = WORD_SIZE'(STEP);
  localparam logic [WORD_SIZE:0]   c_step_ext = (WORD_SIZE+1)'(STEP);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WORD_SIZE-1:0] value_q [CHANNELS];
  logic [WORD_SIZE-1:0] value_d [CHANNELS];
  logic [WORD_SIZE-1:0] limit_q [CHANNELS];
  logic [WORD_SIZE-1:0] limit_d [CHANNELS];
  logic [CHANNELS-1:0]  wrap_q;
  logic [CHANNELS-1:0]  wrap_d;

  // --------------------------------------------------------------------------
  // Next-state computation
  //
  // Channels are walked from 0 upward so that, with cascading enabled, the
  // wrap of channel k can be handed to channel k+1 in the same pass. Only the
  // selected channel can start a chain, and every channel above it is
  // unselected, so a cascaded increment never collides with a direct command.
  // --------------------------------------------------------------------------
  always_comb begin
    logic                 hit;
    logic                 do_inc;
    logic                 do_dec;
    logic [WORD_SIZE:0]   sum;
`ifdef COUNTER_CASCADE_EN
    logic                 carry;
    carry  = 1'b0;
`endif
    hit    = 1'b0;
    do_inc = 1'b0;
    do_dec = 1'b0;
    sum    = '0;
    wrap_d = '0;

    for (int k = 0; k < CHANNELS; k++) begin
      value_d[k] = value_q[k];
      limit_d[k] = limit_q[k];

      hit = (sel == SEL_W'(k));

      // inc together with dec cancels out; write_en and clr pre-empt both.
      do_inc = hit & inc & ~dec & ~write_en & ~clr;
      do_dec = hit & dec & ~inc & ~write_en & ~clr;

`ifdef COUNTER_CASCADE_EN
      do_inc = do_inc | carry;
      carry  = 1'b0;
`endif

      sum = {1'b0, value_q[k]} + c_step_ext;

      if (hit && write_en) begin
        // Loaded as-is even above the limit; the next inc will wrap it.
        value_d[k] = data_in;
      end else if (hit && clr) begin
        value_d[k] = '0;
      end else if (do_inc) begin
        if (sum > {1'b0, limit_q[k]}) begin
          value_d[k] = '0;
          wrap_d[k]  = 1'b1;
`ifdef COUNTER_CASCADE_EN
          carry      = 1'b1;
`endif
        end else begin
          value_d[k] = sum[WORD_SIZE-1:0];
        end
      end else if (do_dec) begin
        if (value_q[k] < c_step) begin
          value_d[k] = limit_q[k];
          wrap_d[k]  = 1'b1;
        end else begin
          value_d[k] = value_q[k] - c_step;
        end
      end

      // Independent of the value commands: the decisions above already used
      // the old limit, the new one is visible from the next cycle.
      if (hit && limit_en) begin
        limit_d[k] = data_in;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        value_q[k] <= '0;
        limit_q[k] <= '1;
      end
      wrap_q <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        value_q[k] <= value_d[k];
        limit_q[k] <= limit_d[k];
      end
      wrap_q <= wrap_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    data_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) begin
        data_out = value_q[k];
      end
    end
  end

  generate
    for (genvar k = 0; k < CHANNELS; k++) begin : g_channel_out
      assign all_out[k*WORD_SIZE +: WORD_SIZE] = value_q[k];
      assign at_limit[k]                       = (value_q[k] == limit_q[k]);
    end
  endgenerate

  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_counter_bank
// Description : Self-checking bench for reg_counter_bank (16-bit, 4 channels,
//               STEP=1). Directed scenarios followed by random commands, all
//               compared every cycle against an arithmetic reference model.
//               Honours COUNTER_CASCADE_EN the same way the design does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_counter_bank;

  localparam int WS   = 16;
  localparam int CH   = 4;
  localparam int STP  = 1;
  localparam int SW   = 2;
  localparam int MAXV = (1 << WS) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [SW-1:0]   sel;
  logic            write_en;
  logic            limit_en;
  logic [WS-1:0]   data_in;
  logic            clr;
  logic            inc;
  logic            dec;
  logic [WS-1:0]   data_out;
  logic [CH*WS-1:0] all_out;
  logic [CH-1:0]   wrap;
  logic [CH-1:0]   at_limit;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int m_val [CH];
  int m_lim [CH];
  bit [CH-1:0] m_wrap;

  reg_counter_bank #(.WORD_SIZE(WS), .CHANNELS(CH), .STEP(STP)) dut (
    .clk(clk), .rst(rst), .sel(sel), .write_en(write_en), .limit_en(limit_en),
    .data_in(data_in), .clr(clr), .inc(inc), .dec(dec), .data_out(data_out),
    .all_out(all_out), .wrap(wrap), .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of the specified behaviour, from the inputs as driven.
  task automatic model_step();
    int s;
    int k;
    bit more;
    m_wrap = '0;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_val[i] = 0;
        m_lim[i] = MAXV;
      end
      return;
    end
    s = int'(sel);
    if (s >= CH) return;
    if (write_en) m_val[s] = int'(data_in);
    else if (clr) m_val[s] = 0;
    else if (inc && !dec) begin
      k = s;
      more = 1'b1;
      while (more) begin
        more = 1'b0;
        if (m_val[k] + STP > m_lim[k]) begin
          m_val[k] = 0;
          m_wrap[k] = 1'b1;
`ifdef COUNTER_CASCADE_EN
          if (k < CH - 1) begin
            k++;
            more = 1'b1;
          end
`endif
        end else begin
          m_val[k] = m_val[k] + STP;
        end
      end
    end else if (dec && !inc) begin
      if (m_val[s] < STP) begin
        m_val[s] = m_lim[s];
        m_wrap[s] = 1'b1;
      end else begin
        m_val[s] = m_val[s] - STP;
      end
    end
    // Limit applied last so this cycle's wrap decisions see the old limit.
    if (limit_en) m_lim[s] = int'(data_in);
  endtask

  task automatic check_all();
    logic [CH*WS-1:0] exp_all;
    logic [CH-1:0]    exp_at;
    logic [WS-1:0]    exp_do;
    exp_do = '0;
    for (int i = 0; i < CH; i++) begin
      exp_all[i*WS +: WS] = WS'(m_val[i]);
      exp_at[i] = (m_val[i] == m_lim[i]);
      if (int'(sel) == i) exp_do = WS'(m_val[i]);
    end
    check("all_out", 64'(all_out), 64'(exp_all));
    check("wrap", 64'(wrap), 64'(m_wrap));
    check("at_limit", 64'(at_limit), 64'(exp_at));
    check("data_out", 64'(data_out), 64'(exp_do));
  endtask

  // Drive one cycle of commands, clock it, then compare against the model.
  task automatic cyc(input bit r, input int s, input bit we, input bit le,
                     input int d, input bit c, input bit i, input bit dc);
    @(negedge clk);
    rst = r; sel = SW'(s); write_en = we; limit_en = le;
    data_in = WS'(d); clr = c; inc = i; dec = dc;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; sel = '0; write_en = 1'b0; limit_en = 1'b0;
    data_in = '0; clr = 1'b0; inc = 1'b0; dec = 1'b0;

    // Reset overrides a simultaneous write.
    cyc(1, 0, 1, 0, 16'h1234, 0, 0, 0);
    check("rst_all_out", 64'(all_out), 64'd0);
    check("rst_at_limit", 64'(at_limit), 64'd0);

    // Channel 2, limit 3, four increments.
    cyc(0, 2, 0, 1, 3, 0, 0, 0);
    cyc(0, 2, 0, 0, 0, 0, 1, 0);
    check("c2_inc1", 64'(data_out), 64'd1);
    cyc(0, 2, 0, 0, 0, 0, 1, 0);
    cyc(0, 2, 0, 0, 0, 0, 1, 0);
    check("c2_inc3", 64'(data_out), 64'd3);
    check("c2_atlim", 64'(at_limit[2]), 64'd1);
    check("c2_nowrap", 64'(wrap[2]), 64'd0);
    cyc(0, 2, 0, 0, 0, 0, 1, 0);
    check("c2_inc4", 64'(data_out), 64'd0);
    check("c2_wrap", 64'(wrap), 64'b0100);
    cyc(0, 2, 0, 0, 0, 0, 0, 0);
    check("c2_wrap_gone", 64'(wrap), 64'd0);

    // Write beats inc; inc+dec cancels.
    cyc(0, 1, 1, 0, 16'h00A5, 0, 1, 0);
    check("c1_write", 64'(data_out), 64'h00A5);
    cyc(0, 1, 0, 0, 0, 0, 1, 1);
    check("c1_incdec", 64'(data_out), 64'h00A5);
    check("c1_incdec_wrap", 64'(wrap), 64'd0);

    // Channel 3 underflow.
    cyc(0, 3, 0, 1, 5, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, 0, 0, 1);
    check("c3_dec_under", 64'(data_out), 64'd5);
    check("c3_dec_wrap", 64'(wrap), 64'b1000);
    cyc(0, 3, 0, 0, 0, 0, 0, 1);
    check("c3_dec2", 64'(data_out), 64'd4);

    // Cascade: limit0=1, limit1=2, clear both, six incs on channel 0.
    cyc(0, 0, 0, 1, 1, 1, 0, 0);
    cyc(0, 1, 0, 1, 2, 1, 0, 0);
    for (int n = 1; n <= 6; n++) begin
      cyc(0, 0, 0, 0, 0, 0, 1, 0);
`ifdef COUNTER_CASCADE_EN
      if (n == 4) check("casc_v1_4", 64'(all_out[WS +: WS]), 64'd2);
      if (n == 6) check("casc_wrap_6", 64'(wrap[1:0]), 64'b11);
`else
      if (n == 4) check("nocasc_v1_4", 64'(all_out[WS +: WS]), 64'd0);
      if (n == 6) check("nocasc_wrap_6", 64'(wrap[1:0]), 64'b01);
`endif
    end

    // Reset mid-count with inc.
    cyc(0, 0, 1, 1, 7, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, 0);
    check("rst_mid_val", 64'(all_out[WS-1:0]), 64'd0);
    check("rst_mid_wrap", 64'(wrap), 64'd0);
    cyc(0, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    check("rst_mid_atlim", 64'(at_limit), 64'd0);

    // Random commands with small limits so wraps are frequent.
    for (int n = 0; n < 600; n++) begin
      int d;
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MAXV))
                                      : int'($urandom_range(0, 6));
      cyc(($urandom_range(0, 60) == 0), int'($urandom_range(0, CH - 1)),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), d,
          ($urandom_range(0, 14) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_counter_bank.md
REG_COUNTER_BANK -- requirements
Module: reg_counter_bank

Interface
REQ-001 Parameter WORD_SIZE, default 16: width of every channel value and limit.
REQ-002 Parameter CHANNELS, default 4: number of independent counter channels (>=1).
REQ-003 Parameter STEP, default 1: increment/decrement amount (1 <= STEP < 2^WORD_SIZE).
REQ-004 Derived SEL_W = max(1, clog2(CHANNELS)).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 sel  input  SEL_W  selects the target channel for write_en/limit_en/clr/inc/dec and data_out; values >= CHANNELS make all commands no-ops.
REQ-008 write_en  input  1  load data_in into value[sel].
REQ-009 limit_en  input  1  load data_in into limit[sel].
REQ-010 data_in  input  WORD_SIZE  load data.
REQ-011 clr  input  1  clear value[sel] to 0.
REQ-012 inc  input  1  step value[sel] up.
REQ-013 dec  input  1  step value[sel] down.
REQ-014 data_out  output  WORD_SIZE  value[sel], combinational read of the registered value; 0 when sel >= CHANNELS.
REQ-015 all_out  output  CHANNELS*WORD_SIZE  all values, channel k at bits [k*WORD_SIZE +: WORD_SIZE].
REQ-016 wrap  output  CHANNELS  registered one-cycle pulse per channel on wrap/underflow.
REQ-017 at_limit  output  CHANNELS  combinational, bit k = (value[k] == limit[k]).

Function
REQ-018 Value command priority per cycle: write_en > clr > inc/dec; lower-priority value commands are ignored that cycle.
REQ-019 limit_en is independent of the value commands and SHALL take effect in the same cycle as any of them; inc/dec wrap decisions that cycle use the old limit.
REQ-020 inc and dec both asserted (with no write_en/clr) SHALL leave value[sel] unchanged and assert no wrap.
REQ-021 inc: compute n = value + STEP in WORD_SIZE+1 bits; if n > limit then value <= 0 and wrap[sel] pulses next cycle, else value <= n[WORD_SIZE-1:0].
REQ-022 dec: if value < STEP then value <= limit and wrap[sel] pulses, else value <= value - STEP.
REQ-023 write_en with data_in > limit SHALL load unchanged; the next inc wraps to 0 per REQ-021.
REQ-024 wrap bits SHALL be 0 in every cycle that does not follow a wrap event; unselected channels hold unless cascaded (REQ-029).
REQ-025 All updates take effect one clock after the command; data_out/all_out reflect them in that cycle.

Reset
REQ-026 While rst=1 at a rising edge, all value[k] <= 0, all limit[k] <= all-ones, wrap <= 0, overriding every command in that cycle.
REQ-027 After reset: data_out=0, all_out=0, wrap=0, at_limit=0.

Configuration
REQ-028 Macro COUNTER_CASCADE_EN selects inc cascading.
REQ-029 With COUNTER_CASCADE_EN defined: an inc wrap on channel k < CHANNELS-1 SHALL apply an inc (REQ-021 rule, own limit) to channel k+1 in the same cycle, rippling upward; each wrapping channel pulses its wrap bit; dec never cascades; a write_en/clr on sel does not cascade.
REQ-030 Without COUNTER_CASCADE_EN: no cascade logic is present; wraps only pulse wrap[sel].

Verification (WORD_SIZE=16, CHANNELS=4, STEP=1)
REQ-031 Assert rst 1 cycle with write_en=1, data_in=0x1234 -> all_out=0, wrap=0, at_limit=0.
REQ-032 sel=2, limit_en data_in=3, then 4x inc -> data_out 1,2,3,0; at_limit[2]=1 at 3; wrap[2] pulses exactly once, cycle after the 4th inc.
REQ-033 sel=1, write_en=1 and inc=1 with data_in=0x00A5 -> 0x00A5; then inc=dec=1 -> stays 0x00A5, wrap=0.
REQ-034 sel=3, limit=5, value 0, dec -> value 5, wrap[3] pulse; dec again -> 4.
REQ-035 limit[0]=1, limit[1]=2, sel=0, 6x inc -> with COUNTER_CASCADE_EN value[1] sequence 0,1,1,2,2,0 and wrap[1] pulses after 6th inc; without macro value[1] stays 0.
REQ-036 Mid-count (value[0]=0x0007) assert rst with inc=1 -> value[0]=0, limit[0]=0xFFFF next cycle, no wrap pulse.
